// File: rtl/mt_thread_scheduler.sv
// Hardware-thread scheduler for the multithreaded RV32I core: picks the issuing
// thread each cycle (fine or quantum-based coarse switching), skipping idle contexts.
module mt_thread_scheduler #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = $clog2(NUM_THREADS),
  parameter int unsigned QUANTUM     = 8,
  parameter int unsigned QCNT_W      = $clog2(QUANTUM + 1)
) (
  input  logic                   clock,
  input  logic                   async_reset,
  input  logic                   MT,
  input  logic                   coarse,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic                   stall,
  output logic [TID_W-1:0]       tid,
  output logic                   tid_valid,
  output logic                   switch,
  output logic [QCNT_W-1:0]      qcnt
);

  localparam int unsigned QLAST = QUANTUM - 1;

  logic [TID_W-1:0]  nxt;
  logic              nxt_found;
  int unsigned       scan_idx;

  logic [TID_W-1:0]  tid_n;
  logic              valid_n;
  logic              switch_n;
  logic [QCNT_W-1:0] qcnt_n;

  // Cyclic scan from tid+1 up to and including tid itself.
  always_comb begin
    nxt       = tid;
    nxt_found = 1'b0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
      scan_idx = int'(tid) + k;
      if (scan_idx >= NUM_THREADS) begin
        scan_idx = scan_idx - NUM_THREADS;
      end
      if (!nxt_found && thread_active[TID_W'(scan_idx)]) begin
        nxt       = TID_W'(scan_idx);
        nxt_found = 1'b1;
      end
    end
  end

  // Next-state selection; stall leaves everything but the switch pulse untouched.
  always_comb begin
    tid_n    = tid;
    valid_n  = tid_valid;
    switch_n = 1'b0;
    qcnt_n   = qcnt;
    if (!stall) begin
      if (!MT) begin
        tid_n    = '0;
        valid_n  = thread_active[0];
        qcnt_n   = '0;
        switch_n = (tid != '0);
      end else if (thread_active == '0) begin
        valid_n = 1'b0;
        qcnt_n  = '0;
      end else if (!coarse || (qcnt == QCNT_W'(QLAST)) || !thread_active[tid]) begin
        tid_n    = nxt;
        qcnt_n   = '0;
        switch_n = (nxt != tid);
        valid_n  = thread_active[nxt];
      end else begin
        qcnt_n  = qcnt + QCNT_W'(1);
        valid_n = thread_active[tid];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!async_reset) begin
      tid       <= '0;
      tid_valid <= 1'b0;
      switch    <= 1'b0;
      qcnt      <= '0;
    end else begin
      tid       <= tid_n;
      tid_valid <= valid_n;
      switch    <= switch_n;
      qcnt      <= qcnt_n;
    end
  end

endmodule

// File: tb/tb_mt_thread_scheduler.sv
// Directed bench for mt_thread_scheduler (4 threads, quantum 8); expected
// output tuples are hand-derived per scenario.
module tb_mt_thread_scheduler;

  logic       clock = 1'b0;
  logic       async_reset;
  logic       MT;
  logic       coarse;
  logic [3:0] thread_active;
  logic       stall;
  logic [1:0] tid;
  logic       tid_valid;
  logic       switch;
  logic [3:0] qcnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] obs;
  logic [7:0] exp_v;
  assign obs = {tid, tid_valid, switch, qcnt};

  mt_thread_scheduler dut (
    .clock(clock), .async_reset(async_reset), .MT(MT), .coarse(coarse),
    .thread_active(thread_active), .stall(stall), .tid(tid),
    .tid_valid(tid_valid), .switch(switch), .qcnt(qcnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    async_reset = 1'b0; MT = 1'b1; coarse = 1'b1; thread_active = 4'b1111; stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {2'd0, 1'b0, 1'b0, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
    async_reset = 1'b1; MT = 1'b0; coarse = 1'b0; thread_active = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {2'd0, 1'b1, 1'b0, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_release[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_fine_round_robin();
    logic [1:0] seq [6] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
    MT = 1'b1; coarse = 1'b0; thread_active = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = {seq[i], 1'b1, 1'b1, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL fine[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_coarse_quantum();
    coarse = 1'b1; thread_active = 4'b1111;
    // tid 0 entered with qcnt 0; 7 more edges count up, the 8th switches.
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) exp_v = {2'd0, 1'b1, 1'b0, 4'(i)};
      else       exp_v = {2'd1, 1'b1, 1'b1, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL coarse[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
    for (int i = 1; i <= 3; i++) tick();
    exp_v = {2'd1, 1'b1, 1'b0, 4'd3};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL coarse_q3: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
    thread_active = 4'b1101;
    tick();
    exp_v = {2'd2, 1'b1, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL coarse_drop: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
  endtask

  task automatic test_stall_single();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = {2'd2, 1'b1, 1'b0, 4'd2};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stall[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
    stall = 1'b0; thread_active = 4'b0100;
    // Sole active thread: count 3..7, wrap to 0 and 1 without a switch.
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_v = {2'd2, 1'b1, 1'b0, 4'((i + 3) % 8)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_mt_drop_empty();
    thread_active = 4'b1000;
    tick();
    exp_v = {2'd3, 1'b1, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL to_t3: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
    MT = 1'b0;
    tick();
    exp_v = {2'd0, 1'b0, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mt_drop: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
    MT = 1'b1; thread_active = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = {2'd0, 1'b0, 1'b0, 4'd0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL empty[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_mode_change();
    logic [7:0] tbl [4];
    thread_active = 4'b1111; coarse = 1'b1;
    tbl[0] = {2'd0, 1'b1, 1'b0, 4'd1};
    tbl[1] = {2'd0, 1'b1, 1'b0, 4'd2};
    tbl[2] = {2'd1, 1'b1, 1'b1, 4'd0};
    tbl[3] = {2'd1, 1'b1, 1'b0, 4'd1};
    for (int i = 0; i < 4; i++) begin
      coarse = (i != 2);
      tick();
      exp_v = tbl[i];
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mode[%0d]: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
                 i, obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    thread_active = 4'b0100;
    tick();
    exp_v = {2'd2, 1'b1, 1'b1, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_setup: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
    for (int i = 0; i < 5; i++) tick();
    exp_v = {2'd2, 1'b1, 1'b0, 4'd5};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_q5: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
    async_reset = 1'b0;
    tick();
    exp_v = {2'd0, 1'b0, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
    async_reset = 1'b1; MT = 1'b0; thread_active = 4'b0001;
    tick();
    exp_v = {2'd0, 1'b1, 1'b0, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_release: tid=%0d v=%0b sw=%0b q=%0d expected tid=%0d v=%0b sw=%0b q=%0d",
               obs[7:6], obs[5], obs[4], obs[3:0], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
  endtask

  initial begin
    test_reset();
    test_fine_round_robin();
    test_coarse_quantum();
    test_stall_single();
    test_mt_drop_empty();
    test_mode_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
